// File: rtl/tank_pkg.sv
// Shared types, default constants and helpers for the tank pump scheduler.
package tank_pkg;

  localparam int DEF_N_TANKS    = 4;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_MIN_RUN    = 16;
  localparam int DEF_MAX_RUN    = 1024;

  // Widest supported tank vector and the index width needed to address it.
  localparam int MAX_TANKS = 16;
  localparam int IDX_MAX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FILL   = 2'd2
  } tank_state_e;

  // Index of the set bit in a one-hot vector (zero when the vector is empty).
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_TANKS-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_TANKS; i++) begin
      idx = idx | (oh[i] ? IDX_MAX_W'(i) : {IDX_MAX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/tank_rr_arb.sv
// Combinational round-robin arbiter: the search starts at last_grant+1 and
// wraps, so the most recently served tank has the lowest priority.
module tank_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  logic [N-1:0]     grant_s;
  logic [IDX_W-1:0] idx_s;
  logic             hit_s;
  logic             found_s;

  // Walk the tanks in rotated order and keep the first requester only.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx_s          = IDX_W'((int'(last_grant_i) + off) % N);
      hit_s          = en_i & ~found_s & req_i[idx_s];
      grant_s[idx_s] = hit_s;
      found_s        = found_s | hit_s;
    end
  end

  assign grant_o = grant_s;
  assign valid_o = |grant_s;

endmodule

// File: rtl/tank_pump_sched.sv
// Shared-pump scheduler: grants one pump to low tanks in round-robin order,
// opens the tank's valve, lets it settle, then pumps until the high mark,
// a minimum run is met, or a timeout latches a fault.
// Optional build macro TANK_SENSOR_SYNC_EN adds a 2-flop synchronizer on
// the lo/hi sensor inputs (2 extra cycles of sensor latency).
module tank_pump_sched
  import tank_pkg::*;
#(
  parameter int N_TANKS    = DEF_N_TANKS,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int MIN_RUN    = DEF_MIN_RUN,
  parameter int MAX_RUN    = DEF_MAX_RUN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_TANKS-1:0] lo,
  input  logic [N_TANKS-1:0] hi,
  input  logic [N_TANKS-1:0] fault_clr,
  output logic [N_TANKS-1:0] valve_sel,
  output logic               pump_on,
  output logic               busy,
  output logic [N_TANKS-1:0] fault
);

  localparam int IDX_W = $clog2(N_TANKS);
  localparam int CNT_W = $clog2(MAX_RUN);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_RUN - 1);

  tank_state_e        state_q;
  logic [N_TANKS-1:0] valve_q;
  logic               pump_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [N_TANKS-1:0] fault_q;
  logic [N_TANKS-1:0] fault_d;

  logic [N_TANKS-1:0] lo_s;
  logic [N_TANKS-1:0] hi_s;
  logic [N_TANKS-1:0] req_s;
  logic [N_TANKS-1:0] incons_s;
  logic [N_TANKS-1:0] grant_s;
  logic               grant_valid_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               sel_hi_s;
  logic               sel_incons_s;
  logic               abort_s;
  logic               fill_done_s;
  logic               timeout_s;
  logic [N_TANKS-1:0] timeout_vec_s;

`ifdef TANK_SENSOR_SYNC_EN
  logic [N_TANKS-1:0] lo_meta_q;
  logic [N_TANKS-1:0] lo_sync_q;
  logic [N_TANKS-1:0] hi_meta_q;
  logic [N_TANKS-1:0] hi_sync_q;

  // Two-flop synchronizer; lo resets to "above low mark", hi to "below high"
  // so a reset never looks like a request or an inconsistency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_meta_q <= '1;
      lo_sync_q <= '1;
      hi_meta_q <= '0;
      hi_sync_q <= '0;
    end else begin
      lo_meta_q <= lo;
      lo_sync_q <= lo_meta_q;
      hi_meta_q <= hi;
      hi_sync_q <= hi_meta_q;
    end
  end

  assign lo_s = lo_sync_q;
  assign hi_s = hi_sync_q;
`else
  assign lo_s = lo;
  assign hi_s = hi;
`endif

  // A tank asks for water when it is below both marks and not faulted;
  // "below low but above high" can only be a broken sensor.
  assign req_s    = ~lo_s & ~hi_s & ~fault_q;
  assign incons_s = ~lo_s & hi_s;

  assign sel_hi_s     = hi_s[last_grant_q];
  assign sel_incons_s = incons_s[last_grant_q];

  tank_rr_arb #(
    .N     (N_TANKS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i        (req_s),
    .last_grant_i (last_grant_q),
    .en_i         (en),
    .grant_o      (grant_s),
    .valid_o      (grant_valid_s)
  );

  assign grant_idx_s = IDX_W'(onehot_to_idx(MAX_TANKS'(grant_s)));

  // Exit conditions of the active fill; hi beats timeout because at the
  // last count the minimum run is always satisfied.
  always_comb begin
    abort_s     = 1'b0;
    fill_done_s = 1'b0;
    timeout_s   = 1'b0;
    if (state_q == ST_FILL) begin
      abort_s     = ~en | sel_incons_s;
      fill_done_s = sel_hi_s & (cnt_q >= MIN_LAST);
      timeout_s   = ~abort_s & ~fill_done_s & (cnt_q == MAX_LAST);
    end else if (state_q == ST_SETTLE) begin
      abort_s     = ~en;
      fill_done_s = 1'b0;
      timeout_s   = 1'b0;
    end else begin
      abort_s     = 1'b0;
      fill_done_s = 1'b0;
      timeout_s   = 1'b0;
    end
  end

  assign timeout_vec_s = {{(N_TANKS-1){1'b0}}, timeout_s} << last_grant_q;

  // Fault next state: sets (inconsistency or timeout) win over a clear.
  always_comb begin
    fault_d = (fault_q & ~fault_clr) | incons_s | timeout_vec_s;
  end

  // Latched per-tank faults.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_d;
    end
  end

  // Scheduler FSM with all pump/valve outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      valve_q      <= '0;
      pump_q       <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= IDX_W'(N_TANKS - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_s) begin
            state_q      <= ST_SETTLE;
            valve_q      <= grant_s;
            busy_q       <= 1'b1;
            cnt_q        <= '0;
            last_grant_q <= grant_idx_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            valve_q <= '0;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= ST_FILL;
            pump_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FILL: begin
          if (abort_s || fill_done_s || timeout_s) begin
            state_q <= ST_IDLE;
            valve_q <= '0;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valve_q <= '0;
          pump_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign valve_sel = valve_q;
  assign pump_on   = pump_q;
  assign busy      = busy_q;
  assign fault     = fault_q;

endmodule
